spi_master_tx: RTL
==================

# spi_master_tx

SPI mode-0 master transmitter that serialises one DATA_WIDTH-bit word per frame onto SCK/MOSI/CS, MSB first. It is the host-side counterpart of the team's FPGA SPI slave receiver. That receiver synchronises SCK/CS through a 2-flop chain plus an edge detector and therefore samples MOSI up to 3 i_clk cycles after a rising SCK edge. This block lets FPGA-side logic (or a loopback bench) drive that receiver from the same i_clk domain. All SPI outputs are registered and glitch-free.

## Interface
- CLK_DIV, 8, i_clk cycles per SCK half-period; legal range ≥4.
- DATA_WIDTH, 8, bits per frame; legal range ≥2.
- CS_SETUP, 8, i_clk cycles from CS fall to the first SCK rise; legal range ≥4.
- CS_HOLD, 8, i_clk cycles from the last SCK fall to CS rise; legal range ≥1.
- CS_GAP, 8, i_clk cycles CS stays high before o_ready reasserts; legal range ≥4.

Ports:
- i_clk  input  1  system clock; the only clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  frame request; accepted only in a cycle where o_ready=1.
- i_data  input  DATA_WIDTH  word to send; sampled in the accept cycle.
- o_ready  output  1  block idle and able to accept i_start.
- o_done  output  1  one-cycle pulse marking frame completion.
- o_sck  output  1  SPI clock; idles low.
- o_mosi  output  1  serial data, MSB first.
- o_cs  output  1  chip select, active low; idles high.

## Operation
- States: IDLE → SETUP → HIGH ↔ LOW → HOLD → GAP → IDLE.
- Reset (async, i_rst=1): state IDLE, o_cs=1, o_sck=0, o_mosi=0, o_done=0, o_ready=1, shift register=0, counters=0. Asserting reset mid-frame aborts the frame immediately: no o_done pulse, and there is no GAP after the reset is released.
- IDLE: o_ready=1. If i_start=1, latch i_data into the shift register and go to SETUP. i_start while o_ready=0 is ignored and is not queued.
- SETUP: o_cs=0, o_mosi=data[DATA_WIDTH-1], o_sck=0. Hold for CS_SETUP cycles, then go to HIGH.
- HIGH: o_sck=1 for CLK_DIV cycles. o_mosi does not change.
- At the end of HIGH:
  - If bits remain, go to LOW. In that same transition o_sck→0 and o_mosi takes the next bit (shift left).
  - If this was bit DATA_WIDTH, go to HOLD with o_sck→0.
- LOW: o_sck=0 for CLK_DIV cycles, then return to HIGH.
- Bit counter: counts rising edges 1..DATA_WIDTH; width is clog2(DATA_WIDTH+1).
- Half-period counter: width clog2(max(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP)). It reloads on every state change and never wraps mid-phase.
- HOLD: o_cs=0, o_sck=0, o_mosi holds the LSB. After CS_HOLD cycles go to GAP; on that transition o_cs→1, o_mosi→0, and o_done=1 for exactly one cycle.
- GAP: o_cs=1, o_ready=0 for CS_GAP cycles, then IDLE.
- Exactly DATA_WIDTH rising SCK edges occur per frame. SCK never toggles while o_cs=1.

## Timing
- Let T be the accept cycle (i_start=1 and o_ready=1 sampled at an i_clk rising edge). Outputs change at the edges below, expressed as T+n.
- T+1: o_cs=0, o_ready=0, o_mosi=MSB.
- Rising edge of bit k (k=0..DATA_WIDTH-1) at T+1+CS_SETUP+2k·CLK_DIV. Falling edge of bit k at that time plus CLK_DIV.
- Last falling edge at F=T+1+CS_SETUP+(2·DATA_WIDTH−1)·CLK_DIV.
- CS rise and o_done pulse at F+CS_HOLD.
- o_ready=1 at F+CS_HOLD+CS_GAP.
- Defaults: first rise T+9, last rise T+121, F=T+129, CS rise/o_done T+137, ready T+145. Back-to-back frame period is 145 cycles.
- MOSI stability: MOSI changes only together with a falling SCK edge, so it is stable for CLK_DIV ≥4 cycles after each rising edge. This meets the receiver's sampling delay of up to 3 cycles.
- o_done is never asserted together with o_ready=1.

## Test plan
- Reset then idle 20 cycles → o_cs=1, o_sck=0, o_mosi=0, o_ready=1, o_done=0, with no toggling.
- Defaults, send 0xA5 → exactly 8 SCK rises. MOSI sampled at each rise reads 1,0,1,0,0,1,0,1. Edge times match T+9…T+129. o_done pulses once at T+137. o_ready returns at T+145.
- Loopback into the team's SPI slave receiver (same i_clk), send 0x3C then 0xFF back-to-back → receiver reports 0x3C then 0xFF with one done pulse per frame.
- Assert i_start continuously with i_data changing every cycle → each frame sends the word present in its accept cycle, and no request is accepted while o_ready=0.
- Assert i_rst at the 4th SCK rise of a 0x81 frame → outputs return to idle values asynchronously with no o_done. After release, a 0x81 request completes normally.
- CLK_DIV=4, DATA_WIDTH=16, send 0x8001 → 16 rises spaced 8 cycles apart, MOSI MSB=1 and LSB=1, all other bits 0.

Source files
------------

// File: rtl/spi_master_tx.sv
// spi_master_tx: SPI mode-0 master transmitter. It sends one DATA_WIDTH-bit
// word per frame, MSB first, on o_sck/o_mosi/o_cs. All SPI outputs are
// registered. MOSI changes only together with a falling SCK edge, so it stays
// stable for CLK_DIV cycles after each rising edge.
//
// Ports:
//   i_clk    system clock, the only clock
//   i_rst    asynchronous active-high reset; aborts any frame in flight
//   i_start  frame request, accepted only while o_ready=1
//   i_data   word to send, sampled in the accept cycle
//   o_ready  idle and able to accept i_start
//   o_done   one-cycle pulse when CS rises at the end of a frame
//   o_sck    SPI clock, idles low
//   o_mosi   serial data, MSB first
//   o_cs     chip select, active low
module spi_master_tx #(
  parameter int CLK_DIV    = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CS_SETUP   = 8,
  parameter int CS_HOLD    = 8,
  parameter int CS_GAP     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_sck,
  output logic                  o_mosi,
  output logic                  o_cs
);

  localparam int MAX_AB = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_CD = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXP);
  localparam int BW     = $clog2(DATA_WIDTH + 1);

  // Counters hold "cycles remaining minus one" so a phase ends at zero.
  localparam logic [CW-1:0] L_DIV   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] L_SETUP = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] L_HOLD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(CS_GAP - 1);
  localparam logic [BW-1:0] L_BITS  = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP
  } state_t;

  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [BW-1:0]         r_bits, w_bits;
  logic [DATA_WIDTH-1:0] r_shift, w_shift;
  logic                  r_cs, w_cs;
  logic                  r_sck, w_sck;
  logic                  r_mosi, w_mosi;
  logic                  r_done, w_done;
  logic                  r_ready, w_ready;
  logic                  w_last;

  assign w_last = (r_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_cs    <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bits  <= w_bits;
      r_shift <= w_shift;
      r_cs    <= w_cs;
      r_sck   <= w_sck;
      r_mosi  <= w_mosi;
      r_done  <= w_done;
      r_ready <= w_ready;
    end
  end

  // Next-state logic also produces the next value of every registered
  // output, so each output toggles on exactly the edge of its state change.
  always_comb begin
    w_state = r_state;
    w_cnt   = w_last ? r_cnt : r_cnt - CW'(1);
    w_bits  = r_bits;
    w_shift = r_shift;
    w_cs    = r_cs;
    w_sck   = r_sck;
    w_mosi  = r_mosi;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (i_start) begin
          w_state = S_SETUP;
          w_cnt   = L_SETUP;
          w_bits  = '0;
          w_shift = i_data;
          w_cs    = 1'b0;
          w_mosi  = i_data[DATA_WIDTH-1];
        end
      end
      S_SETUP, S_LOW: begin
        if (w_last) begin
          w_state = S_HIGH;
          w_cnt   = L_DIV;
          w_sck   = 1'b1;
          w_bits  = r_bits + BW'(1);
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_sck = 1'b0;
          if (r_bits == L_BITS) begin
            w_state = S_HOLD;
            w_cnt   = L_HOLD;
          end else begin
            w_state = S_LOW;
            w_cnt   = L_DIV;
            w_shift = {r_shift[DATA_WIDTH-2:0], 1'b0};
            w_mosi  = r_shift[DATA_WIDTH-2];
          end
        end
      end
      S_HOLD: begin
        if (w_last) begin
          w_state = S_GAP;
          w_cnt   = L_GAP;
          w_cs    = 1'b1;
          w_mosi  = 1'b0;
          w_done  = 1'b1;
        end
      end
      S_GAP: begin
        if (w_last) begin
          w_state = S_IDLE;
          w_cnt   = '0;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_cnt   = '0;
        w_cs    = 1'b1;
        w_sck   = 1'b0;
        w_mosi  = 1'b0;
      end
    endcase
    w_ready = (w_state == S_IDLE);
  end

  assign o_ready = r_ready;
  assign o_done  = r_done;
  assign o_sck   = r_sck;
  assign o_mosi  = r_mosi;
  assign o_cs    = r_cs;

endmodule
